// File: rtl/ipf_pkg.sv
// Shared types and constants for the IPF result-memory write scheduler.
package ipf_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int IPF_ADDR_W = 14;
    localparam int IPF_DATA_W = 8;

    localparam logic LANE0 = 1'b0;
    localparam logic LANE1 = 1'b1;
endpackage

// File: rtl/ipf_wr_sched_rr_arb2.sv
// Two-request round-robin arbiter; last_grant_i names the lane that won most recently.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       advance_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);
    always_comb begin
        grant_o = 2'b00;
        if (advance_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                // On a tie the lane that did not win last time goes first.
                2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end
endmodule

// File: rtl/ipf_wr_sched.sv
// Two-lane round-robin write scheduler feeding the single IPF memory write port.
module ipf_wr_sched
    import ipf_pkg::*;
#(
    parameter int ADDR_W = IPF_ADDR_W,
    parameter int DATA_W = IPF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              l0_valid,
    input  logic [DATA_W-1:0] l0_data,
    output logic              l0_ready,
    input  logic              l1_valid,
    input  logic [DATA_W-1:0] l1_data,
    output logic              l1_ready,
    output logic              ipf_valid,
    output logic [ADDR_W-1:0] ipf_addr,
    output logic [DATA_W-1:0] ipf_data,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = ADDR_W - 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [2];
    logic [1:0]         fin_q;
    logic               last_grant_q;
    logic               ipf_valid_q;
    logic [ADDR_W-1:0]  ipf_addr_q;
    logic [DATA_W-1:0]  ipf_data_q;

    logic               run;
    logic [1:0]         req;
    logic [1:0]         grant;

    assign run = (state_q == ST_RUN);
    assign req = {l1_valid, l0_valid} & ~fin_q;

    rr_arb2 u_arb (
        .req_i        (req),
        .advance_i    (run),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            // Both fin flags set means the final write is already on ipf_* this cycle.
            ST_RUN:  if (&fin_q) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            fin_q        <= 2'b00;
            last_grant_q <= LANE1;
            ipf_valid_q  <= 1'b0;
            ipf_addr_q   <= '0;
            ipf_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start) begin
                cnt_q[0]     <= '0;
                cnt_q[1]     <= '0;
                fin_q        <= 2'b00;
                last_grant_q <= LANE1;
            end
            // Counters saturate into the fin flag so an address is never written twice.
            for (int k = 0; k < 2; k++) begin
                if (grant[k]) begin
                    if (&cnt_q[k]) fin_q[k] <= 1'b1;
                    else           cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
            if (|grant) last_grant_q <= grant[1];
            ipf_valid_q <= |grant;
            if (grant[0]) begin
                ipf_addr_q <= {LANE0, cnt_q[0]};
                ipf_data_q <= l0_data;
            end else if (grant[1]) begin
                ipf_addr_q <= {LANE1, cnt_q[1]};
                ipf_data_q <= l1_data;
            end
        end
    end

    assign l0_ready  = grant[0];
    assign l1_ready  = grant[1];
    assign ipf_valid = ipf_valid_q;
    assign ipf_addr  = ipf_addr_q;
    assign ipf_data  = ipf_data_q;
    assign busy      = run;
    assign done      = (state_q == ST_DONE);
endmodule
